// File: rtl/ccff_chain_loader_pkg.sv
// ccff_pkg: FSM states and counter-width helper shared by the configuration-chain blocks.
package ccff_pkg;
   typedef enum logic [1:0] {IDLE, FETCH, SHIFT, DONE} state_t;
   function automatic int cnt_w(input int n);
      return $clog2(n + 1);
   endfunction
endpackage

// File: rtl/ccff_chain_loader_if.sv
// ccff_chain_loader_if: valid/ready bitstream word stream feeding the chain loader.
interface ccff_chain_loader_if #(parameter int WORD_W = 8);
   logic [WORD_W-1:0] cfg_data;
   logic              cfg_valid;
   logic              cfg_ready;
   modport master (output cfg_data, cfg_valid, input cfg_ready);
   modport slave (input cfg_data, cfg_valid, output cfg_ready);
endinterface

// File: rtl/ccff_piso.sv
// ccff_piso: parallel-in/serial-out word register, MSB first, with a local count of bits still to send.
module ccff_piso #(
   parameter int WORD_W = 8,
   parameter int CW     = $clog2(WORD_W + 1)
) (
   input  logic              prog_clk,
   input  logic              pReset_n,
   input  logic              load,
   input  logic              shift,
   input  logic [WORD_W-1:0] data,
   input  logic [CW-1:0]     load_cnt,
   output logic              msb,
   output logic              last
);
   logic [WORD_W-1:0] sr;
   logic [CW-1:0]     cnt;
   always_ff @(posedge prog_clk or negedge pReset_n)
      if (!pReset_n) begin
         sr  <= '0;
         cnt <= '0;
      end else if (load) begin
         sr  <= data;
         cnt <= load_cnt;
      end else if (shift) begin
         sr  <= sr << 1;
         cnt <= cnt - 1'b1;
      end
   assign msb  = sr[WORD_W-1];
   assign last = cnt == CW'(1);
endmodule

// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: serialises exactly CHAIN_LEN bitstream bits into ccff_head, then releases I/O isolation.
module ccff_chain_loader
   import ccff_pkg::*;
#(
   parameter int WORD_W    = 8,
   parameter int CHAIN_LEN = 1024,
   parameter int CNT_W     = cnt_w(CHAIN_LEN)
) (
   input  logic               prog_clk,
   input  logic               pReset_n,
   input  logic               start,
   ccff_chain_loader_if.slave cfg,
   output logic               ccff_head,
   output logic               chain_shift_en,
   output logic               IO_ISOL_N,
   output logic               busy,
   output logic               done,
   output logic [CNT_W-1:0]   bits_left
);
   localparam int PW = cnt_w(WORD_W);
   state_t           state, state_d;
   logic             ready_d, head_d, shen_d, isol_d, busy_d, done_d;
   logic [CNT_W-1:0] bits_d;
   logic             load, shift, msb, last;
   logic [PW-1:0]    load_cnt;
   // a final partial word only carries the bits the chain still needs
   assign load_cnt = (int'(bits_left) < WORD_W) ? PW'(bits_left) : PW'(WORD_W);
   ccff_piso #(.WORD_W(WORD_W), .CW(PW)) u_piso (
      .prog_clk (prog_clk),
      .pReset_n (pReset_n),
      .load     (load),
      .shift    (shift),
      .data     (cfg.cfg_data),
      .load_cnt (load_cnt),
      .msb      (msb),
      .last     (last)
   );
   always_ff @(posedge prog_clk or negedge pReset_n)
      if (!pReset_n) begin
         state          <= IDLE;
         cfg.cfg_ready  <= 1'b0;
         ccff_head      <= 1'b0;
         chain_shift_en <= 1'b0;
         IO_ISOL_N      <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
         bits_left      <= '0;
      end else begin
         state          <= state_d;
         cfg.cfg_ready  <= ready_d;
         ccff_head      <= head_d;
         chain_shift_en <= shen_d;
         IO_ISOL_N      <= isol_d;
         busy           <= busy_d;
         done           <= done_d;
         bits_left      <= bits_d;
      end
   always_comb begin
      state_d = state;
      ready_d = 1'b0;
      head_d  = 1'b0;
      shen_d  = 1'b0;
      isol_d  = IO_ISOL_N;
      busy_d  = busy;
      done_d  = done;
      bits_d  = bits_left;
      load    = 1'b0;
      shift   = 1'b0;
      case (state)
         IDLE:
            if (start) begin
               state_d = FETCH;
               ready_d = 1'b1;
               busy_d  = 1'b1;
               done_d  = 1'b0;
               isol_d  = 1'b0;
               bits_d  = CNT_W'(CHAIN_LEN);
            end
         FETCH: begin
            load    = cfg.cfg_valid && cfg.cfg_ready;
            state_d = load ? SHIFT : FETCH;
            ready_d = !load;
         end
         SHIFT: begin
            shift  = 1'b1;
            head_d = msb;
            shen_d = 1'b1;
            bits_d = bits_left - 1'b1;
            if (bits_left == CNT_W'(1))
               state_d = DONE;
            else if (last) begin
               state_d = FETCH;
               ready_d = 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            isol_d  = 1'b1;
         end
      endcase
   end
endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb_ccff_chain_loader: three loader instances (CHAIN_LEN 16/12/5) driven from a vector table,
// with a head-bit scoreboard and a model 4x4-bit fabric chain behind the 16-bit instance.
module tb_ccff_chain_loader;
   typedef struct {
      int          k;
      int          gap;
      int          nw;
      logic [7:0]  w0;
      logic [7:0]  w1;
      int          exp_en;
      logic [15:0] exp_bits;
   } vec_t;
   logic             prog_clk = 1'b0;
   logic             pReset_n = 1'b0;
   logic [2:0]       start;
   logic [2:0]       valid;
   logic [2:0][7:0]  data;
   logic [2:0]       ready_o, head_o, shen_o, iso_o, busy_o, done_o;
   logic [2:0][15:0] bl_o;
   int               errors = 0;
   int               checks = 0;
   int               rem[3];
   int               en_cnt[3];
   int               done_rise[3];
   logic [15:0]      cap[3];
   logic             done_prev[3];
   int               en_base, rise_base;
   logic             exp_q[$];
   logic             hist[$];
   logic [15:0]      chain = '0;
   vec_t             vecs[5];
   always #5 prog_clk = ~prog_clk;
   for (genvar g = 0; g < 3; g++) begin : gen_dut
      localparam int LEN = g == 0 ? 16 : (g == 1 ? 12 : 5);
      logic [$clog2(LEN+1)-1:0] bl;
      ccff_chain_loader_if #(.WORD_W(8)) cif ();
      assign cif.cfg_data  = data[g];
      assign cif.cfg_valid = valid[g];
      assign ready_o[g]    = cif.cfg_ready;
      assign bl_o[g]       = 16'(bl);
      ccff_chain_loader #(.WORD_W(8), .CHAIN_LEN(LEN)) dut (
         .prog_clk       (prog_clk),
         .pReset_n       (pReset_n),
         .start          (start[g]),
         .cfg            (cif),
         .ccff_head      (head_o[g]),
         .chain_shift_en (shen_o[g]),
         .IO_ISOL_N      (iso_o[g]),
         .busy           (busy_o[g]),
         .done           (done_o[g]),
         .bits_left      (bl)
      );
   end
   function automatic int len_of(input int k);
      return k == 0 ? 16 : (k == 1 ? 12 : 5);
   endfunction
   task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h", nm, k, act, exp);
      end
   endtask
   // every gated edge pops one expected head bit and clocks the model chain
   task automatic monitor();
      forever begin
         @(negedge prog_clk);
         for (int k = 0; k < 3; k++) begin
            if (busy_o[k]) chk("isol_while_busy", k, 32'(iso_o[k]), 0);
            if (shen_o[k]) begin
               en_cnt[k]++;
               cap[k] = {cap[k][14:0], head_o[k]};
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_bit dut%0d: got an enabled bit, expected none", k);
               end else chk("head", k, 32'(head_o[k]), 32'(exp_q.pop_front()));
               if (k == 0) begin
                  if (hist.size() >= 16) chk("tail", 0, 32'(chain[15]), 32'(hist.pop_front()));
                  hist.push_back(head_o[0]);
                  chain = {chain[14:0], head_o[0]};
               end
            end
            if (done_o[k] && !done_prev[k]) done_rise[k]++;
            done_prev[k] = done_o[k];
         end
      end
   endtask
   task automatic start_pass(input int k);
      start[k]  = 1'b1;
      rem[k]    = len_of(k);
      en_base   = en_cnt[k];
      rise_base = done_rise[k];
      @(negedge prog_clk);
      start[k] = 1'b0;
      chk("start_busy", k, 32'(busy_o[k]), 1);
      chk("start_done", k, 32'(done_o[k]), 0);
      chk("start_isol", k, 32'(iso_o[k]), 0);
      chk("start_bits_left", k, 32'(bl_o[k]), len_of(k));
      chk("start_ready", k, 32'(ready_o[k]), 1);
   endtask
   task automatic send_word(input int k, input logic [7:0] w);
      int n = 0;
      int nb;
      data[k]  = w;
      valid[k] = 1'b1;
      while (!ready_o[k] && n < 50) begin
         @(negedge prog_clk);
         n++;
      end
      chk("ready_timeout", k, 32'(ready_o[k]), 1);
      if (ready_o[k]) begin
         nb = rem[k] < 8 ? rem[k] : 8;
         for (int i = 0; i < nb; i++) exp_q.push_back(w[7-i]);
         rem[k] -= nb;
         @(negedge prog_clk);
      end
      valid[k] = 1'b0;
   endtask
   task automatic stall(input int k, input int gap);
      int n = 0;
      while (!ready_o[k] && n < 50) begin
         @(negedge prog_clk);
         n++;
      end
      repeat (gap) begin
         @(negedge prog_clk);
         chk("gap_shen", k, 32'(shen_o[k]), 0);
         chk("gap_ready", k, 32'(ready_o[k]), 1);
      end
   endtask
   // holds a spare word valid until done to prove no word beyond the pass is readied
   task automatic finish_pass(input int k, input int exp_en, input logic [15:0] exp_bits);
      int n = 0;
      int extra = 0;
      logic [31:0] mask;
      mask     = (32'h1 << exp_en) - 1;
      data[k]  = 8'hAA;
      valid[k] = 1'b1;
      while (!done_o[k] && n < 100) begin
         @(negedge prog_clk);
         extra += 32'(ready_o[k]);
         n++;
      end
      chk("done", k, 32'(done_o[k]), 1);
      chk("done_isol", k, 32'(iso_o[k]), 1);
      chk("done_busy", k, 32'(busy_o[k]), 0);
      chk("done_bits_left", k, 32'(bl_o[k]), 0);
      chk("done_shen", k, 32'(shen_o[k]), 0);
      chk("done_head", k, 32'(head_o[k]), 0);
      chk("en_count", k, en_cnt[k] - en_base, exp_en);
      chk("head_seq", k, 32'(cap[k]) & mask, 32'(exp_bits) & mask);
      chk("queue_drained", k, exp_q.size(), 0);
      if (k == 0) chk("chain", 0, 32'(chain), 32'(exp_bits));
      repeat (3) begin
         @(negedge prog_clk);
         extra += 32'(ready_o[k]);
      end
      chk("no_extra_ready", k, extra, 0);
      chk("done_hold", k, 32'(done_o[k]), 1);
      chk("isol_hold", k, 32'(iso_o[k]), 1);
      chk("done_pulses", k, done_rise[k] - rise_base, 1);
      valid[k] = 1'b0;
   endtask
   task automatic run_vec(input vec_t v);
      start_pass(v.k);
      send_word(v.k, v.w0);
      if (v.nw > 1) begin
         if (v.gap > 0) stall(v.k, v.gap);
         send_word(v.k, v.w1);
      end
      finish_pass(v.k, v.exp_en, v.exp_bits);
   endtask
   initial begin
      int n;
      logic [15:0] bl_snap;
      start = '0;
      valid = '0;
      data  = '0;
      for (int k = 0; k < 3; k++) begin
         en_cnt[k]    = 0;
         done_rise[k] = 0;
         cap[k]       = '0;
         done_prev[k] = 1'b0;
      end
      vecs[0] = '{0, 0, 2, 8'hA5, 8'h3C, 16, 16'hA53C};
      vecs[1] = '{1, 0, 2, 8'hFF, 8'h0F, 12, 16'h0FF0};
      vecs[2] = '{0, 5, 2, 8'hA5, 8'h3C, 16, 16'hA53C};
      vecs[3] = '{2, 0, 1, 8'hB7, 8'h00, 5, 16'h0016};
      vecs[4] = '{0, 0, 2, 8'h5A, 8'hC3, 16, 16'h5AC3};
      fork
         monitor();
      join_none
      repeat (3) @(negedge prog_clk);
      for (int k = 0; k < 3; k++) begin
         chk("rst_ready", k, 32'(ready_o[k]), 0);
         chk("rst_head", k, 32'(head_o[k]), 0);
         chk("rst_shen", k, 32'(shen_o[k]), 0);
         chk("rst_isol", k, 32'(iso_o[k]), 0);
         chk("rst_busy", k, 32'(busy_o[k]), 0);
         chk("rst_done", k, 32'(done_o[k]), 0);
         chk("rst_bits_left", k, 32'(bl_o[k]), 0);
      end
      pReset_n = 1'b1;
      @(negedge prog_clk);
      for (int i = 0; i < 5; i++) run_vec(vecs[i]);
      // start pulsed mid-shift must not restart the pass
      start_pass(0);
      send_word(0, 8'h96);
      repeat (3) @(negedge prog_clk);
      bl_snap  = bl_o[0];
      start[0] = 1'b1;
      @(negedge prog_clk);
      start[0] = 1'b0;
      chk("restart_busy", 0, 32'(busy_o[0]), 1);
      chk("restart_bits_left", 0, 32'(bl_o[0]), 32'(bl_snap) - 1);
      send_word(0, 8'h69);
      finish_pass(0, 16, 16'h9669);
      // asynchronous reset with 7 bits still to go, then a clean pass
      start_pass(0);
      send_word(0, 8'hA5);
      send_word(0, 8'h3C);
      n = 0;
      while (bl_o[0] != 16'd7 && n < 50) begin
         @(negedge prog_clk);
         n++;
      end
      chk("reach_bits_left_7", 0, 32'(bl_o[0]), 7);
      #2 pReset_n = 1'b0;
      #1;
      chk("arst_ready", 0, 32'(ready_o[0]), 0);
      chk("arst_head", 0, 32'(head_o[0]), 0);
      chk("arst_shen", 0, 32'(shen_o[0]), 0);
      chk("arst_isol", 0, 32'(iso_o[0]), 0);
      chk("arst_busy", 0, 32'(busy_o[0]), 0);
      chk("arst_done", 0, 32'(done_o[0]), 0);
      chk("arst_bits_left", 0, 32'(bl_o[0]), 0);
      repeat (2) @(negedge prog_clk);
      exp_q.delete();
      pReset_n = 1'b1;
      @(negedge prog_clk);
      run_vec(vecs[0]);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end
endmodule
